// File: rtl/sa_output_deskew_pkg.sv
// sa_output_deskew_pkg: default array width, word width (`DATA_SIZE), row FIFO depth and rows per tile
`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif
package sa_output_deskew_pkg;
  localparam int ARRAY_N_DEF = 5;
  localparam int DW_DEF = `DATA_SIZE;
  localparam int DEPTH_DEF = 4;
  localparam int ROWS_DEF = 5;
endpackage

// File: rtl/sa_row_fifo.sv
// sa_row_fifo: W-bit x DEPTH sync FIFO with wrap-bit pointers; ports clk, rst (async), push/din, pop/dout (head, combinational), full, empty
module sa_row_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/sa_output_deskew.sv
// sa_output_deskew: deskews bottom-row psum columns into rows, buffers them in a row FIFO, drains over valid/ready; ports clk, rst, psum_in/psum_valid, out_data/out_valid/out_ready/out_last, overflow (sticky drop flag), rows_done
module sa_output_deskew
  import sa_output_deskew_pkg::*;
#(
  parameter int ARRAY_N = ARRAY_N_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ARRAY_N*DW-1:0]      psum_in,
  input  logic                       psum_valid,
  output logic [ARRAY_N*DW-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       overflow,
  output logic [$clog2(ROWS+1)-1:0]  rows_done
);
  localparam int W = ARRAY_N*DW;
  localparam int RW = $clog2(ROWS+1);
  logic [W-1:0] aligned;
  logic [W:0] head;
  logic [ARRAY_N-2:0] vld_sr;
  logic aligned_valid, full, empty, push, pop, last_tag;
  always_ff @(posedge clk or posedge rst)
    if (rst) vld_sr <= '0;
    else vld_sr <= (vld_sr << 1) | (ARRAY_N-1)'(psum_valid);
  assign aligned_valid = vld_sr[ARRAY_N-2];
  for (genvar j = 0; j < ARRAY_N; j++) begin : g_col
    localparam int D = ARRAY_N-1-j;
    if (D == 0) begin : g_thru
      assign aligned[j*DW +: DW] = psum_in[j*DW +: DW];
    end else begin : g_dly
      logic [D*DW-1:0] sr;
      always_ff @(posedge clk or posedge rst)
        if (rst) sr <= '0;
        else sr <= (sr << DW) | (D*DW)'(psum_in[j*DW +: DW]);
      assign aligned[j*DW +: DW] = sr[D*DW-1 -: DW];
    end
  end
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign push = aligned_valid && (!full || pop);
  assign last_tag = rows_done == RW'(ROWS-1);
  assign out_data = head[W-1:0];
  assign out_last = head[W];
  sa_row_fifo #(.W(W+1), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({last_tag, aligned}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rows_done <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) rows_done <= last_tag ? '0 : rows_done + 1'b1;
      if (aligned_valid && !push) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_sa_output_deskew.sv
// tb_sa_output_deskew: randomized scoreboard bench for sa_output_deskew against a row-queue model
`timescale 1ns/1ps
module tb_sa_output_deskew;
  localparam int N = 5, DW = 16, DEPTH = 4, ROWS = 5, W = N*DW;
  logic clk = 0, rst = 1, psum_valid = 0, out_ready = 0;
  logic [W-1:0] psum_in = '0, out_data, drv_r, p_data;
  logic out_valid, out_last, overflow, p_hold = 0;
  logic [2:0] rows_done;
  int tests = 0, fails = 0, cyc = 0;
  int ready_mode = 0, ready_cyc = -1, last_sched = -100;
  logic [W-1:0] row_at [int];
  logic [W:0] exp_q [$];
  int m_occ = 0, m_rows = 0;
  logic m_ovf = 0;
  bit m_pop, m_al;

  sa_output_deskew #(.ARRAY_N(N), .DW(DW), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .psum_in(psum_in), .psum_valid(psum_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow), .rows_done(rows_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [W:0] act, logic [W:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_row();
    return W'({$urandom, $urandom, $urandom});
  endfunction

  task automatic send(int start, logic [W-1:0] d);
    row_at[start] = d;
    if (start > last_sched) last_sched = start;
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && m_occ == 0 && cyc > last_sched + N + 1) return;
      step(1);
    end
    tests++;
    fails++;
    $display("FAIL drain_timeout: %0d rows still pending, required 0", exp_q.size());
  endtask

  // driver: column j in cycle c carries the word of the row launched at c-j, garbage otherwise
  always @(posedge clk) begin
    #2;
    psum_valid = row_at.exists(cyc);
    for (int j = 0; j < N; j++) begin
      drv_r = row_at.exists(cyc - j) ? row_at[cyc - j] : rand_row();
      psum_in[j*DW +: DW] = drv_r[j*DW +: DW];
    end
    out_ready = ready_mode == 1 ? 1'b1 :
                ready_mode == 2 ? ($urandom_range(0, 3) != 0) :
                ready_mode == 3 ? (cyc == ready_cyc) : 1'b0;
  end

  // reference model: a row launched in cycle t is offered to a DEPTH-row queue at the end of cycle t+N-1
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      row_at.delete();
      m_occ = 0;
      m_rows = 0;
      m_ovf = 0;
    end else begin
      m_pop = m_occ > 0 && out_ready;
      m_al = row_at.exists(cyc - (N-1));
      if (m_pop) m_occ--;
      if (m_al) begin
        if (m_occ < DEPTH) begin
          exp_q.push_back({m_rows == ROWS-1, row_at[cyc - (N-1)]});
          m_occ++;
          m_rows = (m_rows + 1) % ROWS;
        end else m_ovf = 1;
      end
      cyc++;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", W'(out_valid), W'(m_occ > 0));
      chk("overflow", W'(overflow), W'(m_ovf));
      chk("rows_done", W'(rows_done), W'(m_rows));
      if (p_hold) chk("hold_stable", {out_valid, out_data}, {1'b1, p_data});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_row: got %h, required no transfer", {out_last, out_data});
        end else chk("row", {out_last, out_data}, exp_q.pop_front());
      end
      p_hold = out_valid && !out_ready;
      p_data = out_data;
    end else p_hold = 0;
  end

  initial begin
    int s;
    logic [W-1:0] r;
    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_data", W'(out_data), '0);
    chk("rst_out_last", W'(out_last), '0);
    chk("rst_overflow", W'(overflow), '0);
    chk("rst_rows_done", W'(rows_done), '0);
    step(2);
    rst = 0;
    step(2);
    // single row, column j = 0x0100+j, held until explicitly drained
    for (int j = 0; j < N; j++) r[j*DW +: DW] = 16'h0100 + 16'(j);
    s = cyc + 1;
    send(s, r);
    step(N + 4);
    chk("single_rows_done", W'(rows_done), W'(1));
    chk("single_data", W'(out_data), W'(r));
    drain();
    // back-to-back streaming with ready high, completing tiles
    s = cyc + 1;
    for (int k = 0; k < 9; k++) send(s + k, rand_row());
    drain();
    // full queue with a pop in the same cycle the next row aligns
    ready_mode = 0;
    s = cyc + 1;
    for (int k = 0; k < DEPTH; k++) send(s + k, rand_row());
    send(s + 9, rand_row());
    ready_cyc = s + 9 + N - 1;
    ready_mode = 3;
    step(N + 14);
    chk("pop_full_overflow", W'(overflow), '0);
    drain();
    // random handshake
    ready_mode = 2;
    s = cyc + 1;
    for (int k = 0; k < 20; k++) begin
      send(s, rand_row());
      s += $urandom_range(2, 4);
    end
    step(s - cyc + N + 2);
    drain();
    // overflow with ready held low
    ready_mode = 0;
    s = cyc + 1;
    for (int k = 0; k < 5; k++) send(s + k, rand_row());
    step(N + 8);
    chk("ovf_set", W'(overflow), W'(1));
    drain();
    // reset mid-operation: two rows buffered, one in flight
    ready_mode = 0;
    s = cyc + 1;
    send(s, rand_row());
    send(s + 1, rand_row());
    send(s + 3, rand_row());
    step(s + 6 - cyc);
    rst = 1;
    #1;
    chk("mid_rst_out_valid", W'(out_valid), '0);
    chk("mid_rst_out_data", W'(out_data), '0);
    chk("mid_rst_out_last", W'(out_last), '0);
    chk("mid_rst_overflow", W'(overflow), '0);
    chk("mid_rst_rows_done", W'(rows_done), '0);
    step(2);
    rst = 0;
    last_sched = -100;
    step(1);
    s = cyc + 1;
    for (int k = 0; k < 6; k++) send(s + k, rand_row());
    step(N + 1);
    chk("post_rst_rows_done", W'(rows_done), W'(1));
    drain();
    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule

// File: doc/sa_output_deskew.md
# sa_output_deskew

Collects partial-sum results leaving the bottom row of the ARRAY_N×ARRAY_N systolic PE array, where column j's result for a given row appears j cycles after column 0's. Deskews the per-column streams back into whole result rows and buffers them in a small row FIFO. Drains the FIFO to the downstream result buffer over a valid/ready handshake. The array cannot stall, so the block flags rows that arrive while the FIFO is full.

## Interface
Parameters:
- ARRAY_N, 5, array width (columns); one result row = ARRAY_N words
- DW, 16, word width; must equal the PE data width `DATA_SIZE
- DEPTH, 4, FIFO depth in rows; power of two, ≥2
- ROWS, 5, result rows per tile; sets out_last and the row counter wrap

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst, asynchronous, active-high
- psum_in  in  ARRAY_N*DW  bottom-row out_down buses; column j in bits [j*DW +: DW]
- psum_valid  in  1  high in the cycle column 0 carries a valid result word
- out_data  out  ARRAY_N*DW  deskewed row at FIFO head; column j in bits [j*DW +: DW]
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts; a transfer happens when out_valid && out_ready
- out_last  out  1  head row is row ROWS-1 of its tile
- overflow  out  1  sticky; set when an aligned row arrives with the FIFO full
- rows_done  out  $clog2(ROWS+1)  rows accepted into the FIFO in the current tile

## Operation
- Deskew: column j passes through ARRAY_N-1-j register stages, and column ARRAY_N-1 passes through 0 stages. psum_valid passes through ARRAY_N-1 stages to form aligned_valid. All delay stages shift every cycle, with no enable.
- Aligned row = {delayed columns}. It is pushed into the FIFO when aligned_valid is high and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Full and no pop: the row is dropped, overflow is set to 1, and rows_done does not increment. Only rst clears overflow.
- FIFO: rd/wr pointers with an extra wrap bit. Full when the indices are equal and the wrap bits differ; empty when the pointers are equal. Both pointers wrap modulo DEPTH.
- A tag bit per entry stores last. It equals 1 when rows_done == ROWS-1 at push.
- rows_done increments on each accepted push. It wraps to 0 on the push that carries last=1.
- out_data and out_last come from the head entry, read combinationally. They are don't-care when out_valid=0, but are 0 after reset because the memory resets to 0.
- Push and pop in the same cycle:
  - FIFO empty: the push is stored and the row is not bypassed; out_valid rises the next cycle.
  - FIFO full: both occur and occupancy stays DEPTH.
- psum_valid may be asserted on consecutive cycles, giving back-to-back rows at full rate.

## Timing
- psum_valid high in cycle t:
  - the aligned row is written at the end of cycle t+ARRAY_N-1;
  - out_valid is high from cycle t+ARRAY_N.
- With out_ready held high, one row drains per cycle. Steady-state throughput is 1 row/cycle with occupancy ≤1.
- out_valid=1 and the head entry stay stable until a transfer; the block never withdraws valid.
- Reset values: out_valid 0, out_data 0, out_last 0, overflow 0, rows_done 0, all delay stages and FIFO entries 0.
- rst mid-operation clears everything immediately. Rows in the delay line or FIFO are discarded, and any partial tile restarts at row 0.

## Structure
- The shared package/define file holds ARRAY_N, DW (`DATA_SIZE), DEPTH and ROWS defaults.
- One sub-module, sa_row_fifo: a parameterised width/depth synchronous FIFO with full/empty, simultaneous push/pop, and async reset. Width is ARRAY_N*DW+1.
- The deskew delay lines are generated in the top level with a generate loop over columns.

## Test plan
All scenarios use ARRAY_N=5, DW=16, DEPTH=4, ROWS=5.
- Single row: psum_valid=1 at cycle 10; drive column j=0x0100+j at cycle 10+j. Required: out_valid first high at cycle 15, out_data={0x0104,…,0x0100}, out_last=0, rows_done=1.
- Full tile streaming: 5 consecutive rows with out_ready=1. Required: 5 transfers on consecutive cycles, the 5th with out_last=1, then rows_done=0.
- Backpressure/overflow: out_ready=0 while 5 rows are sent. Required:
  - rows 0–3 are stored and row 4 is dropped;
  - overflow=1 from the cycle after row 4 aligns;
  - after releasing out_ready, exactly rows 0–3 drain in order.
- Full with simultaneous pop: fill 4 rows, then align row 5 in the same cycle a transfer occurs. Required: no overflow, occupancy stays 4, and row 5 eventually emerges.
- Handshake stability: randomly toggle out_ready over 20 rows with no overflow condition. Required: out_data is stable while out_valid && !out_ready, and there is no loss or duplication (scoreboard).
- Reset mid-operation: assert rst with 2 rows buffered and 1 in flight. Required: all outputs 0 the same cycle, and after release the next row is tagged row 0 of a new tile.
